// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH general-purpose register bank.
// It has one write/modify port (LOAD/INC/DEC/CLR), two combinational read
// ports, and registered carry/zero flags that describe the last executed
// operation.
// Optional build macro REGFILE_BYPASS_EN: when it is defined, a read port
// that addresses the entry being written this cycle returns the new result
// in the same cycle.
module register_file #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WEN,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdat,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdat_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdat_b,
  output logic              carry,
  output logic              zero
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_exec;   // the operation really executes this cycle
  logic [WIDTH-1:0] cur_val;   // current contents of the target entry
  logic [WIDTH-1:0] res_val;   // operation result
  logic             res_carry; // carry/borrow produced by the operation
  logic             res_zero;

  // Select the target entry. An out-of-range waddr matches no entry, so the
  // write is suppressed. This case only occurs for non-power-of-two DEPTH.
  always_comb begin
    wr_exec = 1'b0;
    cur_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) begin
        wr_exec = WEN;
        cur_val = mem[i];
      end
    end
  end

  // Compute the operation result and its flags, modulo 2^WIDTH.
  always_comb begin
    res_val   = '0;
    res_carry = 1'b0;
    case (op_e'(op))
      OP_LOAD: res_val = wdat;
      OP_INC: begin
        res_val   = cur_val + 1'b1;
        res_carry = (cur_val == '1);
      end
      OP_DEC: begin
        res_val   = cur_val - 1'b1;
        res_carry = (cur_val == '0);
      end
      OP_CLR:  res_val = '0;
      default: res_val = '0;
    endcase
    res_zero = (res_val == '0);
  end

  // Update the storage array and the flags. Reset takes priority over any
  // operation presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (wr_exec) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) mem[i] <= res_val;
      end
      carry <= res_carry;
      zero  <= res_zero;
    end
  end

  // Read port A. An out-of-range address returns 0.
  always_comb begin
    rdat_a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) rdat_a = mem[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_exec && (raddr_a == waddr)) rdat_a = res_val;
`endif
  end

  // Read port B. An out-of-range address returns 0.
  always_comb begin
    rdat_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_b == ADDR_W'(i)) rdat_b = mem[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_exec && (raddr_b == waddr)) rdat_b = res_val;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives a DEPTH=4 and a DEPTH=3 register_file from the
// same inputs. Both instances have a 2-bit address, so address 3 is out of
// range for the DEPTH=3 copy.
module tb_register_file;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WEN;
  logic [1:0] op;
  logic [1:0] waddr;
  logic [7:0] wdat;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;

  logic [7:0] rdat_a4, rdat_b4, rdat_a3, rdat_b3;
  logic       carry4, zero4, carry3, zero3;

  int checks   = 0;
  int failures = 0;

  // Reference state: the value of each entry and the flags, per instance.
  int mdl [2][4];
  bit mc  [2];
  bit mz  [2];
  int dep [2] = '{4, 3};

  // clock / reset
  always #5 CLK = ~CLK;

  register_file #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .WEN(WEN), .op(op), .waddr(waddr), .wdat(wdat),
    .raddr_a(raddr_a), .rdat_a(rdat_a4), .raddr_b(raddr_b), .rdat_b(rdat_b4),
    .carry(carry4), .zero(zero4)
  );

  register_file #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .WEN(WEN), .op(op), .waddr(waddr), .wdat(wdat),
    .raddr_a(raddr_a), .rdat_a(rdat_a3), .raddr_b(raddr_b), .rdat_b(rdat_b3),
    .carry(carry3), .zero(zero3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic int mread(input int k, input int a);
    return (a < dep[k]) ? mdl[k][a] : 0;
  endfunction

  // Operation result from the arithmetic rules: values wrap modulo 256.
  function automatic void mop(input int k, input int o, input int a, input int d,
                              output int res, output bit c);
    int v;
    v = mdl[k][a];
    c = 1'b0;
    case (o)
      0: res = d;
      1: begin res = (v + 1) % 256; c = (v == 255); end
      2: begin res = (v + 255) % 256; c = (v == 0); end
      default: res = 0;
    endcase
  endfunction

  // Drive one cycle, check the reads and flags before the edge, then
  // advance the model across the edge.
  task automatic run(input bit rst, input bit wen, input int o, input int wa,
                     input int wd, input int ra, input int rb);
    int  res;
    bit  c;
    int  ea, eb;
    bit  ex;
    @(negedge CLK);
    RST = rst; WEN = wen; op = 2'(o); waddr = 2'(wa); wdat = 8'(wd);
    raddr_a = 2'(ra); raddr_b = 2'(rb);
    #1;
    for (int k = 0; k < 2; k++) begin
      ex = wen && (wa < dep[k]);
      res = 0; c = 1'b0;
      if (ex) mop(k, o, wa, wd, res, c);
      ea = mread(k, ra);
      eb = mread(k, rb);
`ifdef REGFILE_BYPASS_EN
      if (ex && ra == wa) ea = res;
      if (ex && rb == wa) eb = res;
`endif
      check($sformatf("rdat_a d%0d", dep[k]), (k == 0) ? rdat_a4 : rdat_a3, 8'(ea));
      check($sformatf("rdat_b d%0d", dep[k]), (k == 0) ? rdat_b4 : rdat_b3, 8'(eb));
      check($sformatf("carry d%0d", dep[k]), {7'd0, (k == 0) ? carry4 : carry3}, {7'd0, mc[k]});
      check($sformatf("zero d%0d", dep[k]), {7'd0, (k == 0) ? zero4 : zero3}, {7'd0, mz[k]});
    end
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) mdl[k][i] = 0;
        mc[k] = 1'b0; mz[k] = 1'b0;
      end else if (wen && wa < dep[k]) begin
        mop(k, o, wa, wd, res, c);
        mdl[k][wa] = res;
        mc[k] = c;
        mz[k] = (res == 0);
      end
    end
  endtask

  // Idle cycle on the DEPTH=4 instance, checked against fixed expected values.
  task automatic peek(input string tag, input int ra, input int rb, input int ea,
                      input int eb, input bit ec, input bit ez);
    @(negedge CLK);
    RST = 1'b0; WEN = 1'b0; raddr_a = 2'(ra); raddr_b = 2'(rb);
    #1;
    check({tag, " rdat_a"}, rdat_a4, 8'(ea));
    check({tag, " rdat_b"}, rdat_b4, 8'(eb));
    check({tag, " carry"}, {7'd0, carry4}, {7'd0, ec});
    check({tag, " zero"}, {7'd0, zero4}, {7'd0, ez});
  endtask

  initial begin
    RST = 1'b1; WEN = 1'b0; op = 2'b00; waddr = '0; wdat = '0;
    raddr_a = '0; raddr_b = '0;
    @(posedge CLK);
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mdl[k][i] = 0;
      mc[k] = 1'b0; mz[k] = 1'b0;
    end
    peek("reset", 1, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    // LOAD entry 1
    run(0, 1, 0, 1, 8'hA5, 1, 0);
    peek("load1", 1, 0, 8'hA5, 8'h00, 1'b0, 1'b0);

    // LOAD FE then INC twice
    run(0, 1, 0, 2, 8'hFE, 2, 1);
    run(0, 1, 1, 2, 0, 2, 1);
    peek("inc_ff", 2, 1, 8'hFF, 8'hA5, 1'b0, 1'b0);
    run(0, 1, 1, 2, 0, 2, 1);
    peek("inc_wrap", 2, 1, 8'h00, 8'hA5, 1'b1, 1'b1);

    // CLR then DEC, then flags hold with WEN=0
    run(0, 1, 3, 3, 8'h77, 3, 3);
    run(0, 1, 2, 3, 0, 3, 2);
    peek("dec_wrap", 3, 2, 8'hFF, 8'h00, 1'b1, 1'b0);
    peek("hold", 3, 2, 8'hFF, 8'h00, 1'b1, 1'b0);

    // INC entry 0 while reading it in the same cycle
    run(0, 1, 1, 0, 0, 0, 0);
    peek("inc0_next", 0, 3, 8'h01, 8'hFF, 1'b0, 1'b0);

    // out-of-range write on the DEPTH=3 copy
    run(0, 1, 0, 3, 8'h55, 3, 2);
    @(negedge CLK);
    WEN = 1'b0; raddr_a = 2'd3; raddr_b = 2'd0;
    #1;
    check("d3 oob read", rdat_a3, 8'h00);
    check("d3 oob carry", {7'd0, carry3}, 8'h00);
    check("d3 entry0", rdat_b3, 8'h01);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      run(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // load all entries, then reset with a competing LOAD
    for (int i = 0; i < 4; i++) run(0, 1, 0, i, 8'h11 * (i + 1), i, 0);
    peek("pre_rst", 0, 3, 8'h11, 8'h44, 1'b0, 1'b0);
    run(1, 1, 0, 0, 8'h99, 0, 1);
    peek("rst_a", 0, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    peek("rst_b", 2, 3, 8'h00, 8'h00, 1'b0, 1'b0);
    run(0, 0, 0, 0, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
